bsg_manycore_sdr_test_responder: RTL
====================================

BSG_MANYCORE_SDR_TEST_RESPONDER -- requirements
Module: bsg_manycore_sdr_test_responder

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- addr_width_p, 28, fwd packet address width.
- data_width_p, 32, payload width.
- x_cord_width_p, 7, X coordinate width.
- y_cord_width_p, 7, Y coordinate width.
- mem_els_p, 16, backing-store words (power of 2).
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk_i, in, 1, sole clock.
- reset_i, in, 1, synchronous active-high reset.
- en_i, in, 1, accept enable.
- my_x_i / my_y_i, in, x/y_cord_width_p, own coordinates.
- fwd_v_i, in, 1, request valid.
- fwd_op_i, in, 1, 0=load, 1=store.
- fwd_addr_i, in, addr_width_p, word address.
- fwd_data_i, in, data_width_p, store data.
- fwd_dest_x_i / fwd_dest_y_i, in, x/y_cord_width_p, request destination.
- fwd_src_x_i / fwd_src_y_i, in, x/y_cord_width_p, requester coordinates.
- fwd_ready_o, out, 1, request accept (valid-ready).
- rev_v_o, out, 1, return valid.
- rev_type_o, out, 1, 0=load data, 1=store ack.
- rev_data_o, out, data_width_p, return data.
- rev_dest_x_o / rev_dest_y_o, out, x/y_cord_width_p, return destination.
- rev_ready_i, in, 1, return accept.
- received_o, out, 32, accepted-request count.
- sent_o, out, 32, accepted-return count.
- error_o, out, 1, sticky misroute flag.
REQ-003 SHALL use one clock, clk_i; reset_i SHALL be synchronous and active-high.

Function
REQ-004 SHALL treat a request as accepted in a cycle where fwd_v_i & fwd_ready_o; a return as accepted where rev_v_o & rev_ready_i.
REQ-005 SHALL hold returns in a 2-entry FIFO; fwd_ready_o = en_i & FIFO not full, registered-state only, no combinational path from rev_ready_i or fwd_v_i.
REQ-006 SHALL index memory with fwd_addr_i[log2(mem_els_p)-1:0]; upper address bits ignored.
REQ-007 Store accept: mem[idx] <= fwd_data_i at that clock edge; enqueue {type=1, data=0, dest=src}.
REQ-008 Load accept: enqueue {type=0, data=mem[idx] as of that cycle, dest=src}; store at cycle N followed by load of same idx at N+1 SHALL return the stored value.
REQ-009 Return SHALL appear on rev_v_o no earlier than 1 cycle after acceptance; with empty FIFO and rev_ready_i=1, exactly 1 cycle.
REQ-010 rev_* outputs SHALL be held stable while rev_v_o=1 and rev_ready_i=0.
REQ-011 Returns SHALL leave in acceptance order.
REQ-012 Simultaneous enqueue and dequeue with FIFO at 1 entry SHALL keep occupancy 1; at 2 entries fwd_ready_o=0 that cycle regardless of dequeue.
REQ-013 Misroute (fwd_dest_x_i!=my_x_i or fwd_dest_y_i!=my_y_i) on accept: consume request, no memory write, no return, set error_o=1 until reset; received_o still increments.
REQ-014 received_o / sent_o SHALL increment by 1 per acceptance, wrapping 2^32-1 -> 0.
REQ-015 en_i deassertion SHALL block new accepts only; pending returns continue draining.

Reset
REQ-016 On reset_i: FIFO empty, rev_v_o=0, fwd_ready_o=0 during reset, counters=0, error_o=0, all mem words=0.
REQ-017 Reset mid-operation SHALL discard queued returns; first cycle after reset deassertion fwd_ready_o=en_i.

Verification
REQ-018 Reset, en=1, load addr 5 from src (2,4) -> next cycle rev_v=1, type=0, data=0, dest=(2,4).
REQ-019 Store 0xDEADBEEF addr 3, then load addr 3 (and addr 0x13, aliasing with mem_els_p=16) back-to-back -> ack, 0xDEADBEEF, 0xDEADBEEF in order.
REQ-020 rev_ready_i=0, issue 3 requests -> 2 accepted, fwd_ready_o=0, rev_* stable; release -> 3rd accepted after 1st dequeue, sent=received=3.
REQ-021 Request with dest (9,4) to responder at (8,4) -> no return, error_o=1 sticky, received_o=1, sent_o=0, mem unchanged.
REQ-022 Reset asserted with 2 queued returns -> rev_v_o=0, counters 0, mem reads back 0.
REQ-023 Random 10k requests, random rev_ready_i -> returns match reference model, order preserved, sent_o==received_o after drain.

Source files
------------

// File: rtl/bsg_manycore_sdr_test_responder.sv
// Memory-backed endpoint for the manycore SDR link.
// Serves loads/stores and returns responses through a 2-entry FIFO.
module bsg_manycore_sdr_test_responder #(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int mem_els_p      = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      en_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic                      fwd_v_i,
  input  logic                      fwd_op_i,
  input  logic [addr_width_p-1:0]   fwd_addr_i,
  input  logic [data_width_p-1:0]   fwd_data_i,
  input  logic [x_cord_width_p-1:0] fwd_dest_x_i,
  input  logic [y_cord_width_p-1:0] fwd_dest_y_i,
  input  logic [x_cord_width_p-1:0] fwd_src_x_i,
  input  logic [y_cord_width_p-1:0] fwd_src_y_i,
  output logic                      fwd_ready_o,
  output logic                      rev_v_o,
  output logic                      rev_type_o,
  output logic [data_width_p-1:0]   rev_data_o,
  output logic [x_cord_width_p-1:0] rev_dest_x_o,
  output logic [y_cord_width_p-1:0] rev_dest_y_o,
  input  logic                      rev_ready_i,
  output logic [31:0]               received_o,
  output logic [31:0]               sent_o,
  output logic                      error_o
);

  localparam int lg_els_lp = $clog2(mem_els_p);

  typedef struct packed {
    logic                      typ;
    logic [data_width_p-1:0]   data;
    logic [x_cord_width_p-1:0] x;
    logic [y_cord_width_p-1:0] y;
  } ret_t;

  logic [data_width_p-1:0] mem_r [mem_els_p];
  ret_t                    fifo_r [2];
  logic                    rd_r;
  logic                    wr_r;
  logic [1:0]              cnt_r;
  logic [31:0]             received_r;
  logic [31:0]             sent_r;
  logic                    error_r;

  logic                 acc;
  logic                 hit;
  logic                 enq;
  logic                 deq;
  logic [lg_els_lp-1:0] idx;
  ret_t                 entry;
  logic                 addr_unused;

  // Upper address bits intentionally alias onto the small store.
  assign idx         = fwd_addr_i[lg_els_lp-1:0];
  assign addr_unused = ^fwd_addr_i;

  assign fwd_ready_o = en_i & ~reset_i & (cnt_r != 2'd2);
  assign acc = fwd_v_i & fwd_ready_o;
  assign hit = (fwd_dest_x_i == my_x_i) & (fwd_dest_y_i == my_y_i);
  assign enq = acc & hit;
  assign deq = rev_v_o & rev_ready_i;

  always_comb begin
    entry      = '0;
    entry.typ  = fwd_op_i;
    entry.data = fwd_op_i ? '0 : mem_r[idx];
    entry.x    = fwd_src_x_i;
    entry.y    = fwd_src_y_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_r       <= 1'b0;
      wr_r       <= 1'b0;
      cnt_r      <= 2'd0;
      received_r <= '0;
      sent_r     <= '0;
      error_r    <= 1'b0;
      for (int i = 0; i < mem_els_p; i++) mem_r[i] <= '0;
    end else begin
      if (enq) wr_r <= ~wr_r;
      if (deq) rd_r <= ~rd_r;
      cnt_r <= cnt_r + 2'(enq) - 2'(deq);
      if (acc) received_r <= received_r + 32'd1;
      if (deq) sent_r <= sent_r + 32'd1;
      if (acc & ~hit) error_r <= 1'b1;
      if (enq & fwd_op_i) mem_r[idx] <= fwd_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) fifo_r[wr_r] <= entry;
  end

  assign rev_v_o      = (cnt_r != 2'd0);
  assign rev_type_o   = fifo_r[rd_r].typ;
  assign rev_data_o   = fifo_r[rd_r].data;
  assign rev_dest_x_o = fifo_r[rd_r].x;
  assign rev_dest_y_o = fifo_r[rd_r].y;
  assign received_o   = received_r;
  assign sent_o       = sent_r;
  assign error_o      = error_r;

endmodule
